// File: rtl/systolic_input_fifo_bank.sv
// Per-lane input FIFOs feeding the systolic array edge.
// Lanes pop together; lane k output is skewed by k extra cycles.
module systolic_input_fifo_bank #(
   parameter int data_size   = 16,
   parameter int array_size  = 9,
   parameter int fifo_depth  = 8,
   parameter int full_margin = 3
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            flush,
   input  logic [array_size-1:0]           wr_en,
   input  logic [data_size-1:0]            wr_data,
   input  logic                            rd_en,
   output logic [array_size-1:0]           full,
   output logic [array_size-1:0]           empty,
   output logic [array_size*data_size-1:0] data_out,
   output logic [array_size-1:0]           valid_out,
   output logic                            overflow_err,
   output logic                            underflow_err
);

   localparam int AW = $clog2(fifo_depth);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth);
   localparam logic [CW-1:0] FULL_TH =
      CW'(fifo_depth - full_margin);

   logic                  pop_all;
   logic                  under_hit;
   logic [array_size-1:0] ovf_lane;
   logic                  ovf_q, ovf_d;
   logic                  und_q, und_d;

   assign pop_all   = rd_en & ~(|empty) & ~flush;
   assign under_hit = rd_en & (|empty) & ~flush;

   for (genvar k = 0; k < array_size; k++) begin : g_lane
      logic [data_size-1:0] mem_q [fifo_depth];
      logic [AW-1:0]        wptr_q, rptr_q;
      logic [CW-1:0]        cnt_q, cnt_d;
      logic                 wr_ok;
      logic [data_size-1:0] hd_q;
      logic                 hv_q;
      logic [data_size-1:0] skd_q [k+1];
      logic                 skv_q [k+1];

      assign empty[k] = (cnt_q == '0);
      assign full[k]  = (cnt_q >= FULL_TH);

      // A full lane still accepts a write when it pops in the same cycle.
      assign wr_ok = ~flush & wr_en[k]
                   & ((cnt_q != DEPTH_C) | pop_all);
      assign ovf_lane[k] = ~flush & wr_en[k]
                         & (cnt_q == DEPTH_C) & ~pop_all;

      always_comb begin
         cnt_d = cnt_q;
         if (wr_ok && !pop_all)
            cnt_d = cnt_q + CW'(1);
         else if (!wr_ok && pop_all)
            cnt_d = cnt_q - CW'(1);
      end

      always_ff @(posedge clk) begin
         if (wr_ok)
            mem_q[wptr_q] <= wr_data;
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            hd_q   <= '0;
            hv_q   <= 1'b0;
            for (int j = 0; j <= k; j++) begin
               skd_q[j] <= '0;
               skv_q[j] <= 1'b0;
            end
         end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            hd_q   <= '0;
            hv_q   <= 1'b0;
            for (int j = 0; j <= k; j++) begin
               skd_q[j] <= '0;
               skv_q[j] <= 1'b0;
            end
         end else begin
            if (wr_ok)
               wptr_q <= wptr_q + AW'(1);
            if (pop_all)
               rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_d;
            hd_q  <= pop_all ? mem_q[rptr_q] : '0;
            hv_q  <= pop_all;
            skd_q[0] <= hd_q;
            skv_q[0] <= hv_q;
            for (int j = 1; j <= k; j++) begin
               skd_q[j] <= skd_q[j-1];
               skv_q[j] <= skv_q[j-1];
            end
         end
      end

      assign data_out[k*data_size +: data_size] = skd_q[k];
      assign valid_out[k] = skv_q[k];
   end

   assign ovf_d = ovf_q | (|ovf_lane);
   assign und_d = und_q | under_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_q <= 1'b0;
         und_q <= 1'b0;
      end else if (flush) begin
         ovf_q <= 1'b0;
         und_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         und_q <= und_d;
      end
   end

   assign overflow_err  = ovf_q;
   assign underflow_err = und_q;

endmodule

// File: tb/tb_systolic_input_fifo_bank.sv
// Directed bench for systolic_input_fifo_bank.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_systolic_input_fifo_bank;

   localparam int DW = 16;
   localparam int N  = 9;

   logic            clk;
   logic            reset;
   logic            flush;
   logic [N-1:0]    wr_en;
   logic [DW-1:0]   wr_data;
   logic            rd_en;
   logic [N-1:0]    full;
   logic [N-1:0]    empty;
   logic [N*DW-1:0] data_out;
   logic [N-1:0]    valid_out;
   logic            overflow_err;
   logic            underflow_err;

   int n_chk;
   int n_fail;

   systolic_input_fifo_bank #(
      .data_size  (DW),
      .array_size (N),
      .fifo_depth (8),
      .full_margin(3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .full         (full),
      .empty        (empty),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .overflow_err (overflow_err),
      .underflow_err(underflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [255:0] obs,
                      input logic [255:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] lane(input int k);
      return data_out[k*DW +: DW];
   endfunction

   task automatic do_flush();
      wr_en = '0;
      rd_en = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   initial begin
      int idx0, idx3, idx4;
      logic [N-1:0] ev;
      logic         anyv;
      n_chk   = 0;
      n_fail  = 0;
      reset   = 1'b0;
      flush   = 1'b0;
      wr_en   = '0;
      wr_data = '0;
      rd_en   = 1'b0;
      #2;
      chk("rst_empty", 256'(empty), 256'(9'h1FF));
      chk("rst_full", 256'(full), 256'(0));
      chk("rst_valid", 256'(valid_out), 256'(0));
      chk("rst_data", 256'(data_out), 256'(0));
      chk("rst_ovf", 256'(overflow_err), 256'(0));
      chk("rst_und", 256'(underflow_err), 256'(0));
      tick();
      reset = 1'b1;
      tick();

      // fill lane 0 with 1..5
      wr_en = 9'h001;
      for (int i = 1; i <= 5; i++) begin
         wr_data = 16'(i);
         tick();
         if (i == 4)
            chk("fill_full4", 256'(full[0]), 256'(0));
      end
      chk("fill_full5", 256'(full), 256'(9'h001));
      chk("fill_empty", 256'(empty), 256'(9'h1FE));
      do_flush();
      chk("flush_empty", 256'(empty), 256'(9'h1FF));
      chk("flush_full", 256'(full), 256'(0));

      // skewed single column
      for (int k = 0; k < N; k++) begin
         wr_en   = 9'(1 << k);
         wr_data = 16'(10 + k);
         tick();
      end
      wr_en = '0;
      chk("skew_empty0", 256'(empty), 256'(0));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("skew_v_t", 256'(valid_out), 256'(0));
      chk("skew_empty", 256'(empty), 256'(9'h1FF));
      for (int i = 0; i < N; i++) begin
         tick();
         ev = 9'(1 << i);
         chk("skew_valid", 256'(valid_out), 256'(ev));
         chk("skew_data", 256'(lane(i)), 256'(10 + i));
      end
      tick();
      chk("skew_done", 256'(valid_out), 256'(0));

      // overflow on lane 4
      wr_en = 9'h1EF;
      for (int i = 0; i < 8; i++) begin
         wr_data = 16'(200 + i);
         tick();
      end
      wr_en = 9'h010;
      for (int i = 0; i < 9; i++) begin
         wr_data = 16'(100 + i);
         tick();
         if (i == 7)
            chk("ovf_pre", 256'(overflow_err), 256'(0));
      end
      wr_en = '0;
      chk("ovf_set", 256'(overflow_err), 256'(1));
      chk("ovf_full", 256'(full), 256'(9'h1FF));
      idx0 = 0;
      idx4 = 0;
      for (int c = 0; c < 20; c++) begin
         rd_en = (c < 8);
         tick();
         if (valid_out[0]) begin
            chk("ovf_l0", 256'(lane(0)), 256'(200 + idx0));
            idx0++;
         end
         if (valid_out[4]) begin
            chk("ovf_l4", 256'(lane(4)), 256'(100 + idx4));
            idx4++;
         end
      end
      rd_en = 1'b0;
      chk("ovf_n0", 256'(idx0), 256'(8));
      chk("ovf_n4", 256'(idx4), 256'(8));
      chk("ovf_drained", 256'(empty), 256'(9'h1FF));
      chk("ovf_no_und", 256'(underflow_err), 256'(0));
      do_flush();
      chk("flush_ovf", 256'(overflow_err), 256'(0));

      // underflow: lane 8 empty
      wr_en   = 9'h0FF;
      wr_data = 16'd55;
      tick();
      wr_en = '0;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("und_set", 256'(underflow_err), 256'(1));
      chk("und_empty", 256'(empty), 256'(9'h100));
      anyv = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         anyv = anyv | (|valid_out);
      end
      chk("und_novalid", 256'(anyv), 256'(0));
      chk("und_hold", 256'(empty), 256'(9'h100));
      do_flush();
      chk("flush_und", 256'(underflow_err), 256'(0));

      // wrap with concurrent write and pop at count 8
      wr_en = 9'h1FF;
      for (int i = 0; i < 8; i++) begin
         wr_data = 16'(300 + i);
         tick();
      end
      idx3 = 0;
      for (int c = 0; c < 20; c++) begin
         wr_data = 16'(308 + c);
         rd_en   = 1'b1;
         tick();
         chk("wrap_full", 256'(full), 256'(9'h1FF));
         if (valid_out[3]) begin
            chk("wrap_l3", 256'(lane(3)), 256'(300 + idx3));
            idx3++;
         end
      end
      wr_en = '0;
      for (int c = 0; c < 20; c++) begin
         rd_en = (c < 8);
         tick();
         if (valid_out[3]) begin
            chk("wrap_l3", 256'(lane(3)), 256'(300 + idx3));
            idx3++;
         end
      end
      rd_en = 1'b0;
      chk("wrap_n3", 256'(idx3), 256'(28));
      chk("wrap_empty", 256'(empty), 256'(9'h1FF));
      chk("wrap_ovf", 256'(overflow_err), 256'(0));
      chk("wrap_und", 256'(underflow_err), 256'(0));

      // async reset mid-burst, lane 2 at count 5
      wr_en = 9'h1FF;
      for (int i = 0; i < 5; i++) begin
         wr_data = 16'(400 + i);
         tick();
      end
      wr_en = 9'h004;
      rd_en = 1'b1;
      tick();
      wr_en = '0;
      rd_en = 1'b0;
      tick();
      chk("mid_full", 256'(full), 256'(9'h004));
      chk("mid_valid", 256'(valid_out), 256'(9'h001));
      #2;
      reset = 1'b0;
      #1;
      chk("arst_empty", 256'(empty), 256'(9'h1FF));
      chk("arst_full", 256'(full), 256'(0));
      chk("arst_valid", 256'(valid_out), 256'(0));
      chk("arst_data", 256'(data_out), 256'(0));
      tick();
      reset = 1'b1;
      tick();
      chk("post_empty", 256'(empty), 256'(9'h1FF));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/systolic_input_fifo_bank.md
# systolic_input_fifo_bank

Bank of `array_size` independent lane FIFOs between the image-memory fill controller and the systolic array's input edge. Each lane captures the memory read word when its write-enable bit is set and reports an early-full flag back to the fill controller. All lanes are popped together when the array requests data, and each lane's output is delayed so that lane k reaches the array k cycles after lane 0, forming the diagonal wavefront.

## Interface
Parameters:
- `data_size`, 16, width of one image word
- `array_size`, 9, number of lanes (one per array row / kernel tap)
- `fifo_depth`, 8, entries per lane; power of two, at least 4
- `full_margin`, 3, free-entry reserve covering fill-controller address-to-data latency

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low
- `flush`  in  1  synchronous clear of all lanes, delay lines and error flags
- `wr_en`  in  `array_size`  per-lane write strobe, delayed to align with `wr_data`
- `wr_data`  in  `data_size`  memory read data, shared by all lanes
- `rd_en`  in  1  array requests one wavefront column
- `full`  out  `array_size`  per-lane early-full, fed back as the fill controller's per-lane stall input
- `empty`  out  `array_size`  per-lane empty
- `data_out`  out  `array_size*data_size`  lane k at bits [k*data_size +: data_size], skewed
- `valid_out`  out  `array_size`  lane k valid, skewed identically to data
- `overflow_err`  out  1  sticky: a write hit a lane with count == `fifo_depth`
- `underflow_err`  out  1  sticky: `rd_en` while any lane empty

## Operation
- Per lane: write pointer, read pointer (log2(`fifo_depth`) bits, natural wrap), count (log2(`fifo_depth`)+1 bits), RAM of `fifo_depth` x `data_size`.
- Write: lane k accepts `wr_data` when `wr_en[k]` is 1 and the lane is not at capacity, or when it is at capacity and pops in the same cycle. Multi-hot `wr_en` writes the same word to every selected lane.
- Write to a lane at capacity with no pop: word dropped, pointers unchanged, `overflow_err` set.
- `pop_all` = `rd_en` AND no lane empty. On `pop_all`, every lane reads its head and advances its read pointer.
- `rd_en` with any lane empty: no lane pops, `underflow_err` set, and a zero-valid column enters the skew pipeline.
- Simultaneous write and pop on one lane: count unchanged, both pointers advance. This is legal at count 0 only if the pop was not allowed, because `empty` gates the pop.
- `full[k]` = count[k] >= `fifo_depth` - `full_margin`. `empty[k]` = count[k] == 0. Both are combinational from registered counts.
- Skew: the head word and valid go to stage-0 registers. Lane k then passes through k more registers, so lane 0 has 1 stage and lane `array_size`-1 has `array_size` stages.
- `flush`: pointers, counts, skew registers, `data_out`, `valid_out` and both error flags go to 0 next edge. A `flush` cycle ignores writes and reads.
- The block has no FSM beyond the pointer and count logic. Error flags clear only on `reset` or `flush`.

## Timing
- Reset values: `full`=0, `empty`=all 1, `data_out`=0, `valid_out`=0, `overflow_err`=0, `underflow_err`=0. All pointers, counts and skew stages are 0.
- Reset asserted mid-operation clears everything asynchronously. In-flight wavefronts are lost.
- Write at edge t: count increments at t, and `empty`/`full` reflect the new count right after edge t. The word is poppable in the cycle after t.
- Pop at edge t: lane 0 `data_out`/`valid_out` valid after edge t+1. Lane k is valid after edge t+1+k.
- With `rd_en` held continuously and lanes non-empty, each lane presents a new word every cycle (one column per cycle).
- `full` deasserts the cycle after the pop that drops count below threshold. With `full_margin`=3, a well-behaved fill controller never triggers overflow.

## Test plan
- Reset: assert reset mid-burst with lane 2 at count 5 -> all outputs at reset values immediately; `empty`=9'h1FF.
- Fill: write 1..5 to lane 0 with `fifo_depth`=8 and `full_margin`=3 -> `full[0]` rises after 5th write, count 5.
- Skewed read: write value 10+k into every lane k, pulse `rd_en` at edge t -> `valid_out[k]` is high only after edge t+1+k and `data_out` lane k = 10+k.
- Overflow: 9 writes to lane 4, no reads -> 9th word dropped and `overflow_err`=1. Eight reads then return the first 8 words in order.
- Underflow: lanes 0–7 loaded, lane 8 empty, `rd_en` -> no pointer moves, `underflow_err`=1, no `valid_out` bit rises.
- Wrap and concurrency: lane 3 at count 8, simultaneous write and `pop_all` for 20 cycles -> count stays 8, no error, output order matches input order across pointer wrap.
